// File: rtl/slice_config_loader.sv
// slice_config_loader: streams a slice configuration frame in over valid/ready,
// checks the padding bits, then commits all LUT configs and the carry-chain bit in one cycle.
module slice_config_loader #(
    parameter int S_XX_BASE = 4,
    parameter int CFG_SIZE  = 2**S_XX_BASE + 1,
    parameter int NUM_LUTS  = 4,
    parameter int DATA_W    = 8
) (
    input  logic                         config_clk,
    input  logic                         config_rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [NUM_LUTS*CFG_SIZE-1:0] luts_config_out,
    output logic                         config_use_cc,
    output logic                         config_en,
    output logic                         busy,
    output logic                         done,
    output logic                         frame_err
);
    localparam int FRAME_BITS = NUM_LUTS*CFG_SIZE + 1;
    localparam int NUM_WORDS  = (FRAME_BITS + DATA_W - 1) / DATA_W;
    localparam int PAD_BITS   = NUM_WORDS*DATA_W - FRAME_BITS;
    localparam int STG_W      = FRAME_BITS + PAD_BITS;
    localparam int CNT_W      = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [STG_W-1:0]               stg_q, stg_d, frame;
    logic [NUM_LUTS*CFG_SIZE-1:0]   luts_q, luts_d;
    logic                           cc_q, cc_d;
    logic                           done_q, done_d;
    logic                           err_q, err_d;
    logic                           last, pad_ok;

    always_comb begin
        frame = stg_q;
        frame[cnt_q*DATA_W +: DATA_W] = in_data;
        last    = cnt_q == CNT_W'(NUM_WORDS - 1);
        pad_ok  = (frame >> FRAME_BITS) == '0;
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        luts_d  = luts_q;
        cc_d    = cc_q;
        done_d  = state_q == COMMIT;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                // abort wins over a word arriving on the same edge
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (in_valid) begin
                    stg_d = frame;
                    if (last) begin
                        cnt_d = '0;
                        if (pad_ok) begin
                            {luts_d, cc_d} = frame[FRAME_BITS-1:0];
                            state_d        = COMMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge config_clk or posedge config_rst) begin
        if (config_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stg_q   <= '0;
            luts_q  <= '0;
            cc_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            luts_q  <= luts_d;
            cc_q    <= cc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready        = state_q == LOAD;
    assign busy            = state_q != IDLE;
    assign config_en       = state_q == COMMIT;
    assign done            = done_q;
    assign frame_err       = err_q;
    assign luts_config_out = luts_q;
    assign config_use_cc   = cc_q;
endmodule
